// File: rtl/enigma_encoder_if.sv
// Character and rotor-position bus for the Enigma encoder.
// The master side supplies characters and start positions; the slave side
// (the encoder) returns ciphertext and the live rotor positions.
interface enigma_encoder_if;
  logic        load_pos;
  logic [4:0]  pos_l;
  logic [4:0]  pos_m;
  logic [4:0]  pos_r;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_out;
  logic        out_valid;
  logic [14:0] rotor_pos;

  modport master (
    output load_pos, pos_l, pos_m, pos_r, char_in, char_valid,
    input  char_ready, char_out, out_valid, rotor_pos
  );

  modport slave (
    input  load_pos, pos_l, pos_m, pos_r, char_in, char_valid,
    output char_ready, char_out, out_valid, rotor_pos
  );
endinterface

// File: rtl/enigma_encoder.sv
// Three-rotor Enigma I encryptor: rotors I-II-III (left-middle-right),
// reflector B, ring settings A, no plugboard. One character per three
// cycles: IDLE accepts, STEP advances the rotors, MAP pushes the letter
// through the rotor stack and registers the result.
module enigma_encoder (
  input logic            clk,
  input logic            reset,
  enigma_encoder_if.slave bus
);

  // Rotor and reflector wirings as ASCII strings, entry 0 in the MSBs.
  localparam logic [8*26-1:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*26-1:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [8*26-1:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [8*26-1:0] REFL_B   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  // Turnover positions: middle rotor (II) at E, right rotor (III) at V.
  localparam logic [4:0] NOTCH_M = 5'd4;
  localparam logic [4:0] NOTCH_R = 5'd21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    MAP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        load_en;
  logic        accept;
  logic        step_en;
  logic        map_en;
  logic        ready;

  logic [4:0]  rot_l;
  logic [4:0]  rot_m;
  logic [4:0]  rot_r;

  logic [7:0]  char_p0;
  logic        letter_p0;
  logic [7:0]  offset_p0;
  logic [4:0]  idx_in;

  logic [4:0]  x_r;
  logic [4:0]  x_m;
  logic [4:0]  x_l;
  logic [4:0]  x_refl;
  logic [4:0]  x_li;
  logic [4:0]  x_mi;
  logic [4:0]  x_ri;
  logic [7:0]  mapped_char;

  logic [7:0]  char_out_q;
  logic        out_valid_q;

  // Start positions outside 0..25 are treated as A.
  function automatic logic [4:0] clamp26(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  // Modular add on 0..25 operands; the 6-bit sum never exceeds 50.
  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction

  // Modular subtract on 0..25 operands without borrowing into bit 5.
  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, a} + 6'd26 - {1'b0, b};
    end
    return d[4:0];
  endfunction

  function automatic logic [4:0] wire_at(input logic [8*26-1:0] w, input logic [4:0] k);
    logic [7:0] ch;
    ch = w[8*(25 - int'(k)) +: 8];
    return 5'(ch - 8'h41);
  endfunction

  // Reverse lookup through a wiring: which contact maps to v.
  function automatic logic [4:0] wire_inv(input logic [8*26-1:0] w, input logic [4:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int k = 0; k < 26; k++) begin
      if (wire_at(w, 5'(k)) == v) r = 5'(k);
    end
    return r;
  endfunction

  // Signal entering at contact c of a rotor turned to p, toward the reflector.
  function automatic logic [4:0] rotor_fwd(input logic [8*26-1:0] w, input logic [4:0] c,
                                           input logic [4:0] p);
    return sub26(wire_at(w, add26(c, p)), p);
  endfunction

  // Same rotor, traversed on the way back from the reflector.
  function automatic logic [4:0] rotor_bwd(input logic [8*26-1:0] w, input logic [4:0] c,
                                           input logic [4:0] p);
    return sub26(wire_inv(w, add26(c, p)), p);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state strobes; a position load wins over a character.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    accept    = 1'b0;
    step_en   = 1'b0;
    map_en    = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.load_pos) begin
          load_en = 1'b1;
        end else if (bus.char_valid) begin
          accept    = 1'b1;
          state_nxt = STEP;
        end
      end
      STEP: begin
        step_en   = letter_p0;
        state_nxt = MAP;
      end
      MAP: begin
        map_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: accepted character held for STEP and MAP ----
  // Character latch on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      char_p0 <= bus.char_in;
    end
  end

  assign letter_p0 = (char_p0 >= 8'h41) && (char_p0 <= 8'h5A);
  assign offset_p0 = char_p0 - 8'h41;
  assign idx_in    = letter_p0 ? offset_p0[4:0] : 5'd0;

  // Rotor positions: load in IDLE, step with middle-rotor double-step in STEP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rot_l <= 5'd0;
      rot_m <= 5'd0;
      rot_r <= 5'd0;
    end else if (load_en) begin
      rot_l <= clamp26(bus.pos_l);
      rot_m <= clamp26(bus.pos_m);
      rot_r <= clamp26(bus.pos_r);
    end else if (step_en) begin
      if (rot_m == NOTCH_M) begin
        rot_l <= add26(rot_l, 5'd1);
        rot_m <= add26(rot_m, 5'd1);
      end else if (rot_r == NOTCH_R) begin
        rot_m <= add26(rot_m, 5'd1);
      end
      rot_r <= add26(rot_r, 5'd1);
    end
  end

  // ---- stage p1: rotor path on post-step positions ----
  assign x_r    = rotor_fwd(WIRE_III, idx_in, rot_r);
  assign x_m    = rotor_fwd(WIRE_II,  x_r,    rot_m);
  assign x_l    = rotor_fwd(WIRE_I,   x_m,    rot_l);
  assign x_refl = wire_at(REFL_B, x_l);
  assign x_li   = rotor_bwd(WIRE_I,   x_refl, rot_l);
  assign x_mi   = rotor_bwd(WIRE_II,  x_li,   rot_m);
  assign x_ri   = rotor_bwd(WIRE_III, x_mi,   rot_r);

  assign mapped_char = letter_p0 ? (8'h41 + {3'b000, x_ri}) : char_p0;

  // Output register: result captured in MAP, valid pulse for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_out_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= map_en;
      if (map_en) begin
        char_out_q <= mapped_char;
      end
    end
  end

  assign bus.char_ready = ready;
  assign bus.char_out   = char_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.rotor_pos  = {rot_l, rot_m, rot_r};

endmodule

// File: tb/tb_enigma_encoder.sv
// Bench for enigma_encoder: directed vectors with literal expectations plus a
// string-based Enigma model checked on every out_valid pulse.
module tb_enigma_encoder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  enigma_encoder_if bus ();

  enigma_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0]  cin;
    logic [7:0]  cout;
    logic [14:0] pos;
  } exp_t;

  exp_t exp_q[$];

  string W1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  string W2 = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  string W3 = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  string RB = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  int ml = 0;
  int mm = 0;
  int mr = 0;

  function automatic void check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic int fwd(input string w, input int c, input int p);
    return ((int'(w[(c + p) % 26]) - 65) - p + 26) % 26;
  endfunction

  function automatic int bwd(input string w, input int c, input int p);
    int t;
    t = (c + p) % 26;
    for (int k = 0; k < 26; k++) begin
      if (int'(w[k]) - 65 == t) return (k - p + 26) % 26;
    end
    return 0;
  endfunction

  function automatic bit is_letter(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  // Press one key on the model machine: step, then encipher.
  function automatic logic [7:0] model_enc(input logic [7:0] c);
    int x;
    if (!is_letter(c)) return c;
    if (mm == 4) begin
      ml = (ml + 1) % 26;
      mm = (mm + 1) % 26;
    end else if (mr == 21) begin
      mm = (mm + 1) % 26;
    end
    mr = (mr + 1) % 26;
    x = int'(c) - 65;
    x = fwd(W3, x, mr);
    x = fwd(W2, x, mm);
    x = fwd(W1, x, ml);
    x = int'(RB[x]) - 65;
    x = bwd(W1, x, ml);
    x = bwd(W2, x, mm);
    x = bwd(W3, x, mr);
    return 8'(65 + x);
  endfunction

  function automatic logic [14:0] model_pos();
    return {5'(ml), 5'(mm), 5'(mr)};
  endfunction

  // Every out_valid pulse is matched against the next expected result.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("char_out", int'(bus.char_out), int'(e.cout));
        check("rotor_pos", int'(bus.rotor_pos), int'(e.pos));
        if (is_letter(e.cin)) check("no_self_encrypt", int'(bus.char_out == e.cin), 0);
      end
    end
  end

  task automatic load(input int l, input int m, input int r);
    bus.pos_l    = 5'(l);
    bus.pos_m    = 5'(m);
    bus.pos_r    = 5'(r);
    bus.load_pos = 1'b1;
    @(posedge clk);
    #1;
    bus.load_pos = 1'b0;
    ml = (l > 25) ? 0 : l;
    mm = (m > 25) ? 0 : m;
    mr = (r > 25) ? 0 : r;
  endtask

  task automatic send(input logic [7:0] c, input bit chk_out, input logic [7:0] lit_out,
                      input bit chk_pos, input logic [14:0] lit_pos);
    int   guard;
    exp_t e;
    guard = 0;
    while (!bus.char_ready && guard < 10) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!bus.char_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    e.cin  = c;
    e.cout = model_enc(c);
    e.pos  = model_pos();
    exp_q.push_back(e);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.char_in = 8'($urandom);
    @(negedge clk);
    check("ready_low_step", int'(bus.char_ready), 0);
    bus.char_in = 8'($urandom);
    @(negedge clk);
    check("ready_low_map", int'(bus.char_ready), 0);
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    if (chk_out) check("char_out_literal", int'(bus.char_out), int'(lit_out));
    if (chk_pos) check("rotor_pos_literal", int'(bus.rotor_pos), int'(lit_pos));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string      s1;
    logic [7:0] c;
    s1 = "BDZGO";
    bus.load_pos   = 1'b0;
    bus.pos_l      = 5'd0;
    bus.pos_m      = 5'd0;
    bus.pos_r      = 5'd0;
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;

    // Reset values
    #12;
    check("reset_char_out", int'(bus.char_out), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_char_ready", int'(bus.char_ready), 1);
    check("reset_rotor_pos", int'(bus.rotor_pos), 0);
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // AAAAA from AAA -> BDZGO, ending at AAF
    for (int i = 0; i < 5; i++) begin
      send("A", 1'b1, s1[i], (i == 4), {5'd0, 5'd0, 5'd5});
    end

    // Double step from ADU
    load(0, 3, 20);
    send("K", 1'b0, 8'h00, 1'b1, {5'd0, 5'd3, 5'd21});
    send("E", 1'b0, 8'h00, 1'b1, {5'd0, 5'd4, 5'd22});
    send("Y", 1'b0, 8'h00, 1'b1, {5'd1, 5'd5, 5'd23});

    // Non-letters pass through without stepping
    load(0, 0, 0);
    send(8'h20, 1'b1, 8'h20, 1'b1, 15'd0);
    send("a", 1'b1, "a", 1'b1, 15'd0);

    // Out-of-range start clamps; load beats a simultaneous character
    bus.pos_l      = 5'd2;
    bus.pos_m      = 5'd7;
    bus.pos_r      = 5'd30;
    bus.load_pos   = 1'b1;
    bus.char_in    = "A";
    bus.char_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.load_pos   = 1'b0;
    bus.char_valid = 1'b0;
    ml = 2; mm = 7; mr = 0;
    check("load_prio_ready", int'(bus.char_ready), 1);
    check("load_clamp_pos", int'(bus.rotor_pos), int'({5'd2, 5'd7, 5'd0}));
    repeat (4) @(posedge clk);
    #1;
    check("load_prio_no_step", int'(bus.rotor_pos), int'({5'd2, 5'd7, 5'd0}));

    // ZZZ wraps to ZZA
    load(25, 25, 25);
    send("A", 1'b0, 8'h00, 1'b1, {5'd25, 5'd25, 5'd0});

    // Reset during MAP drops the character
    bus.char_in    = "B";
    bus.char_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_out_valid", int'(bus.out_valid), 0);
    check("midreset_rotor_pos", int'(bus.rotor_pos), 0);
    check("midreset_ready", int'(bus.char_ready), 1);
    check("midreset_char_out", int'(bus.char_out), 0);
    @(posedge clk);
    #1;
    check("midreset_hold_valid", int'(bus.out_valid), 0);
    #2;
    reset = 1'b1;
    ml = 0; mm = 0; mr = 0;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      if (i % 100 == 0) load($urandom_range(25), $urandom_range(25), $urandom_range(25));
      if ($urandom_range(9) == 0) c = 8'($urandom);
      else c = 8'(8'h41 + $urandom_range(25));
      send(c, 1'b0, 8'h00, 1'b0, 15'd0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("pending_results", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
